// File: rtl/dsi_sched_pkg.sv
// Shared types and helpers for the DSI lane scheduler: FSM encoding,
// lane-count bound, byte-count to lane-mask conversion and saturating counter.
package dsi_sched_pkg;

    localparam int unsigned MAX_LANES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HS_ENTER,
        ST_HS_STREAM,
        ST_LP_SEND,
        ST_DRAIN
    } sched_state_e;

    // A byte count of 0 or above the lane count means "all lanes carry data".
    function automatic logic [MAX_LANES-1:0] byte_mask(input logic [2:0] bytes,
                                                       input int unsigned lanes);
        int unsigned          n;
        logic [MAX_LANES-1:0] m;
        n = ((bytes == 3'd0) || (32'(bytes) > lanes)) ? lanes : 32'(bytes);
        m = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
        return (en && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

endpackage

// File: rtl/dsi_byte_striper.sv
// Combinational word-to-lane fan-out: drives per-lane HS request/valid/data and
// trims the unused lanes on the final (possibly partial) word of a burst.
module dsi_byte_striper
    import dsi_sched_pkg::*;
#(
    parameter int unsigned g_num_lanes = 2
) (
    input  logic                     enter_i,
    input  logic                     stream_i,
    input  logic                     pkt_valid_i,
    input  logic                     pkt_last_i,
    input  logic [2:0]               pkt_bytes_i,
    input  logic [8*g_num_lanes-1:0] pkt_data_i,
    output logic [g_num_lanes-1:0]   lane_request_o,
    output logic [g_num_lanes-1:0]   lane_valid_o,
    output logic [8*g_num_lanes-1:0] lane_data_o
);

    logic [MAX_LANES-1:0]   full_mask;
    logic [g_num_lanes-1:0] keep;

    assign full_mask = byte_mask(pkt_bytes_i, g_num_lanes);
    assign keep      = (pkt_valid_i && pkt_last_i) ? full_mask[g_num_lanes-1:0] : '1;

    for (genvar gi = 0; gi < g_num_lanes; gi++) begin : g_lane
        assign lane_request_o[gi]     = enter_i | (stream_i & keep[gi]);
        assign lane_valid_o[gi]       = stream_i & pkt_valid_i & keep[gi];
        assign lane_data_o[gi*8 +: 8] = stream_i ? pkt_data_i[gi*8 +: 8] : 8'h00;
    end

endmodule

// File: rtl/dsi_lane_scheduler.sv
// DSI lane sequencer: arbitrates HS packet bursts against LPDT commands,
// raises/drops lane requests, enforces HS entry timeout and post-burst LP-11 gap.
module dsi_lane_scheduler
    import dsi_sched_pkg::*;
#(
    parameter int unsigned g_num_lanes     = 2,
    parameter int unsigned g_gap_ticks     = 4,
    parameter int unsigned g_timeout_ticks = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tick_i,
    input  logic                     pkt_valid_i,
    input  logic [8*g_num_lanes-1:0] pkt_data_i,
    input  logic [2:0]               pkt_bytes_i,
    input  logic                     pkt_last_i,
    output logic                     pkt_ready_o,
    input  logic                     lp_valid_i,
    input  logic [7:0]               lp_data_i,
    input  logic                     lp_last_i,
    output logic                     lp_ready_o,
    output logic [g_num_lanes-1:0]   lane_hs_request_o,
    output logic [g_num_lanes-1:0]   lane_hs_valid_o,
    output logic [8*g_num_lanes-1:0] lane_hs_data_o,
    input  logic [g_num_lanes-1:0]   lane_hs_ready_i,
    input  logic [g_num_lanes-1:0]   lane_idle_i,
    output logic                     lane_lp_request_o,
    output logic                     lane_lp_valid_o,
    output logic [7:0]               lane_lp_data_o,
    input  logic                     lane_lp_ready_i,
    output logic                     busy_o,
    output logic                     underrun_o,
    output logic                     timeout_o
);

    localparam logic [7:0] GAP_C     = 8'(g_gap_ticks);
    localparam logic [7:0] TIMEOUT_C = 8'(g_timeout_ticks);

    sched_state_e state_q, state_d;
    logic [7:0]   tick_cnt_q, tick_cnt_d;
    logic         last_grant_lp_q, last_grant_lp_d;
    logic         underrun_q, underrun_d;
    logic         timeout_q, timeout_d;

    logic all_idle, all_ready, grant_lp, hs_enter, hs_stream;

    assign all_idle  = &lane_idle_i;
    assign all_ready = &lane_hs_ready_i;

    always_comb begin
        state_d           = state_q;
        tick_cnt_d        = tick_cnt_q;
        last_grant_lp_d   = last_grant_lp_q;
        underrun_d        = underrun_q;
        timeout_d         = timeout_q;
        grant_lp          = 1'b0;
        hs_enter          = 1'b0;
        hs_stream         = 1'b0;
        pkt_ready_o       = 1'b0;
        lp_ready_o        = 1'b0;
        lane_lp_request_o = 1'b0;
        lane_lp_valid_o   = 1'b0;
        lane_lp_data_o    = 8'h00;

        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = 8'd0;
                // With both sources waiting, serve whichever did not win last time.
                grant_lp = (pkt_valid_i && lp_valid_i) ? !last_grant_lp_q : lp_valid_i;
                if (all_idle && (pkt_valid_i || lp_valid_i)) begin
                    last_grant_lp_d = grant_lp;
                    state_d         = grant_lp ? ST_LP_SEND : ST_HS_ENTER;
                end
            end
            ST_HS_ENTER: begin
                hs_enter = 1'b1;
                if (all_ready) begin
                    tick_cnt_d = 8'd0;
                    state_d    = ST_HS_STREAM;
                end else begin
                    tick_cnt_d = sat_inc(tick_cnt_q, tick_i);
                    if (tick_cnt_d >= TIMEOUT_C) begin
                        timeout_d  = 1'b1;
                        tick_cnt_d = 8'd0;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_HS_STREAM: begin
                hs_stream   = 1'b1;
                pkt_ready_o = 1'b1;
                if (!pkt_valid_i) begin
                    underrun_d = 1'b1;
                end else if (pkt_last_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_LP_SEND: begin
                lane_lp_request_o = 1'b1;
                lane_lp_valid_o   = lp_valid_i;
                lane_lp_data_o    = lp_data_i;
                lp_ready_o        = lane_lp_ready_i;
                if (lp_valid_i && lane_lp_ready_i && lp_last_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The gap only counts continuous LP-11 on every lane.
                if (!all_idle) begin
                    tick_cnt_d = 8'd0;
                end else if (GAP_C == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    tick_cnt_d = sat_inc(tick_cnt_q, tick_i);
                    if (tick_cnt_d >= GAP_C) begin
                        tick_cnt_d = 8'd0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            tick_cnt_q      <= 8'd0;
            last_grant_lp_q <= 1'b0;
            underrun_q      <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            tick_cnt_q      <= tick_cnt_d;
            last_grant_lp_q <= last_grant_lp_d;
            underrun_q      <= underrun_d;
            timeout_q       <= timeout_d;
        end
    end

    dsi_byte_striper #(
        .g_num_lanes(g_num_lanes)
    ) u_striper (
        .enter_i       (hs_enter),
        .stream_i      (hs_stream),
        .pkt_valid_i   (pkt_valid_i),
        .pkt_last_i    (pkt_last_i),
        .pkt_bytes_i   (pkt_bytes_i),
        .pkt_data_i    (pkt_data_i),
        .lane_request_o(lane_hs_request_o),
        .lane_valid_o  (lane_hs_valid_o),
        .lane_data_o   (lane_hs_data_o)
    );

    assign busy_o     = (state_q != ST_IDLE);
    assign underrun_o = underrun_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_dsi_lane_scheduler.sv
// Bench for dsi_lane_scheduler: behavioural lanes, tick divider, and
// scoreboards for HS words, LP bytes and grant order.
module tb_dsi_lane_scheduler;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         tick_i = 1'b0;
    logic         pkt_valid_i = 1'b0;
    logic [15:0]  pkt_data_i = '0;
    logic [2:0]   pkt_bytes_i = '0;
    logic         pkt_last_i = 1'b0;
    logic         pkt_ready_o;
    logic         lp_valid_i = 1'b0;
    logic [7:0]   lp_data_i = '0;
    logic         lp_last_i = 1'b0;
    logic         lp_ready_o;
    logic [1:0]   lane_hs_request_o, lane_hs_valid_o;
    logic [15:0]  lane_hs_data_o;
    logic [1:0]   lane_hs_ready_i = '0;
    logic [1:0]   lane_idle_i = '0;
    logic         lane_lp_request_o, lane_lp_valid_o;
    logic [7:0]   lane_lp_data_o;
    logic         lane_lp_ready_i = 1'b0;
    logic         busy_o, underrun_o, timeout_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  mask;
        logic [15:0] data;
    } hs_exp_t;

    hs_exp_t    hs_q[$];
    logic [7:0] lp_q[$];
    int         grant_q[$];
    logic       stuck1 = 1'b0;
    logic       enter_seen = 1'b0;
    logic       lp_req_prev = 1'b0, hs_req_prev = 1'b0;
    logic [1:0] tick_div = '0;
    int         rdy_cnt[2];

    always #5 clk = ~clk;

    dsi_lane_scheduler #(
        .g_num_lanes(N),
        .g_gap_ticks(4),
        .g_timeout_ticks(4)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .tick_i           (tick_i),
        .pkt_valid_i      (pkt_valid_i),
        .pkt_data_i       (pkt_data_i),
        .pkt_bytes_i      (pkt_bytes_i),
        .pkt_last_i       (pkt_last_i),
        .pkt_ready_o      (pkt_ready_o),
        .lp_valid_i       (lp_valid_i),
        .lp_data_i        (lp_data_i),
        .lp_last_i        (lp_last_i),
        .lp_ready_o       (lp_ready_o),
        .lane_hs_request_o(lane_hs_request_o),
        .lane_hs_valid_o  (lane_hs_valid_o),
        .lane_hs_data_o   (lane_hs_data_o),
        .lane_hs_ready_i  (lane_hs_ready_i),
        .lane_idle_i      (lane_idle_i),
        .lane_lp_request_o(lane_lp_request_o),
        .lane_lp_valid_o  (lane_lp_valid_o),
        .lane_lp_data_o   (lane_lp_data_o),
        .lane_lp_ready_i  (lane_lp_ready_i),
        .busy_o           (busy_o),
        .underrun_o       (underrun_o),
        .timeout_o        (timeout_o)
    );

    // Tick every 4 clocks; lanes report hs_ready 2 ticks after request, idle when released.
    always @(posedge clk) begin
        tick_div <= tick_div + 2'd1;
        tick_i   <= (tick_div == 2'd3);
        for (int k = 0; k < N; k++) begin
            if (rst_i || !lane_hs_request_o[k]) begin
                rdy_cnt[k]         <= 0;
                lane_hs_ready_i[k] <= 1'b0;
            end else begin
                if (tick_i && rdy_cnt[k] < 2) rdy_cnt[k] <= rdy_cnt[k] + 1;
                lane_hs_ready_i[k] <= (rdy_cnt[k] >= 2) && !(k == 1 && stuck1);
            end
            lane_idle_i[k] <= !lane_hs_request_o[k] && ((k != 0) || !lane_lp_request_o);
        end
        lane_lp_ready_i <= lane_lp_request_o && !lane_lp_ready_i;
    end

    function automatic logic [1:0] exp_mask(input logic [2:0] b);
        case (b)
            3'd1:    return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_i) begin
            hs_exp_t    e;
            logic [15:0] dm;
            logic [7:0]  le;
            if (pkt_ready_o && lp_ready_o) begin
                errors++;
                $display("FAIL ready_exclusive: pkt_ready=%0b lp_ready=%0b, required not both 1",
                         pkt_ready_o, lp_ready_o);
            end
            if (lane_hs_request_o == 2'b11 && !pkt_ready_o) enter_seen = 1'b1;
            if (|lane_hs_valid_o) begin
                checks++;
                if (hs_q.size() == 0) begin
                    errors++;
                    $display("FAIL hs_unexpected: valid=%b data=%h with no word expected",
                             lane_hs_valid_o, lane_hs_data_o);
                end else begin
                    e  = hs_q.pop_front();
                    dm = {{8{e.mask[1]}}, {8{e.mask[0]}}};
                    if (lane_hs_valid_o !== e.mask || (lane_hs_data_o & dm) !== (e.data & dm)) begin
                        errors++;
                        $display("FAIL hs_word: valid=%b data=%h, required valid=%b data=%h",
                                 lane_hs_valid_o, lane_hs_data_o & dm, e.mask, e.data & dm);
                    end
                end
            end
            if (lane_lp_valid_o && lp_ready_o) begin
                checks++;
                if (lp_q.size() == 0) begin
                    errors++;
                    $display("FAIL lp_unexpected: byte=%h with no byte expected", lane_lp_data_o);
                end else begin
                    le = lp_q.pop_front();
                    if (lane_lp_data_o !== le) begin
                        errors++;
                        $display("FAIL lp_byte: got %h, required %h", lane_lp_data_o, le);
                    end
                end
            end
            if (lane_lp_request_o && !lp_req_prev) grant_q.push_back(0);
            if ((|lane_hs_request_o) && !hs_req_prev) grant_q.push_back(1);
            lp_req_prev = lane_lp_request_o;
            hs_req_prev = |lane_hs_request_o;
        end else begin
            lp_req_prev = 1'b0;
            hs_req_prev = 1'b0;
        end
    end

    task automatic drive_hs_word(input logic [15:0] d, input logic last, input logic [2:0] b);
        hs_exp_t e;
        bit      done = 0;
        e.mask = last ? exp_mask(b) : 2'b11;
        e.data = d;
        hs_q.push_back(e);
        pkt_data_i  = d;
        pkt_last_i  = last;
        pkt_bytes_i = b;
        pkt_valid_i = 1'b1;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            if (pkt_ready_o) begin
                done = 1;
                if (last) begin
                    checks++;
                    if (lane_hs_request_o !== exp_mask(b)) begin
                        errors++;
                        $display("FAIL last_req: got %b, required %b", lane_hs_request_o, exp_mask(b));
                    end
                end
                @(posedge clk);
                #1;
                if (last) begin
                    pkt_valid_i = 1'b0;
                    checks++;
                    if (lane_hs_request_o !== 2'b00) begin
                        errors++;
                        $display("FAIL req_drop: got %b, required 00", lane_hs_request_o);
                    end
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL hs_accept_timeout: word %h never accepted", d);
            pkt_valid_i = 1'b0;
        end
        $display("hs word %h last=%0b bytes=%0d accepted=%0b", d, last, b, done);
    endtask

    task automatic drive_lp_byte(input logic [7:0] d, input logic last);
        bit done = 0;
        lp_q.push_back(d);
        lp_data_i  = d;
        lp_last_i  = last;
        lp_valid_i = 1'b1;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            if (lp_ready_o) begin
                done = 1;
                @(posedge clk);
                #1;
                if (last) begin
                    lp_valid_i = 1'b0;
                    checks++;
                    if (lane_lp_request_o !== 1'b0) begin
                        errors++;
                        $display("FAIL lp_req_drop: got %b, required 0", lane_lp_request_o);
                    end
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL lp_accept_timeout: byte %h never accepted", d);
            lp_valid_i = 1'b0;
        end
        $display("lp byte %h last=%0b accepted=%0b", d, last, done);
    endtask

    task automatic wait_not_busy(input string name);
        bit done = 0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (!busy_o) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: busy still 1 after 500 cycles, required 0", name);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({pkt_ready_o, lp_ready_o, lane_hs_request_o, lane_hs_valid_o, lane_hs_data_o,
             lane_lp_request_o, lane_lp_valid_o, lane_lp_data_o, busy_o, underrun_o,
             timeout_o} !== '0) begin
            errors++;
            $display("FAIL %s: outputs pr=%b lr=%b req=%b val=%b dat=%h lpreq=%b lpval=%b lpdat=%h busy=%b und=%b to=%b, required all 0",
                     name, pkt_ready_o, lp_ready_o, lane_hs_request_o, lane_hs_valid_o,
                     lane_hs_data_o, lane_lp_request_o, lane_lp_valid_o, lane_lp_data_o,
                     busy_o, underrun_o, timeout_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst_i = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_hs_burst();
        enter_seen = 1'b0;
        drive_hs_word(16'hA1B2, 1'b0, 3'd2);
        drive_hs_word(16'hC3D4, 1'b0, 3'd2);
        drive_hs_word(16'h77E5, 1'b1, 3'd1);
        checks++;
        if (enter_seen !== 1'b1) begin
            errors++;
            $display("FAIL hs_enter_wait: ready-before-lanes window seen=%b, required 1", enter_seen);
        end
        wait_not_busy("hs_burst_idle");
        checks++;
        if (underrun_o !== 1'b0 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL hs_flags: underrun=%b timeout=%b, required 0 0", underrun_o, timeout_o);
        end
    endtask

    task automatic test_lp();
        int ticks = 0;
        bit done = 0;
        bit ready_in_drain = 0;
        drive_lp_byte(8'h01, 1'b0);
        drive_lp_byte(8'h02, 1'b0);
        drive_lp_byte(8'hAB, 1'b1);
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (!busy_o) done = 1;
            else begin
                if (pkt_ready_o || lp_ready_o) ready_in_drain = 1;
                if ((&lane_idle_i) && tick_i) ticks++;
            end
        end
        checks++;
        if (!done || ticks != 4) begin
            errors++;
            $display("FAIL lp_gap: busy cleared=%0b after %0d idle ticks, required 1 after 4", done, ticks);
        end
        checks++;
        if (ready_in_drain) begin
            errors++;
            $display("FAIL drain_holdoff: a ready was 1 during drain, required 0");
        end
    endtask

    task automatic test_alternation();
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        grant_q.delete();
        fork
            drive_hs_word(16'h1234, 1'b1, 3'd2);
            drive_lp_byte(8'h55, 1'b1);
        join
        wait_not_busy("alt_round1_idle");
        fork
            drive_hs_word(16'h5A5A, 1'b1, 3'd5);
            drive_lp_byte(8'h77, 1'b1);
        join
        wait_not_busy("alt_round2_idle");
        checks++;
        if (grant_q.size() != 4 || grant_q[0] != 0 || grant_q[1] != 1 ||
            grant_q[2] != 0 || grant_q[3] != 1) begin
            errors++;
            $display("FAIL grant_order: got %p (0=LP 1=HS), required '{0,1,0,1}", grant_q);
        end
    endtask

    task automatic test_underrun();
        bit valid_seen = 0;
        checks++;
        if (underrun_o !== 1'b0) begin
            errors++;
            $display("FAIL underrun_pre: got %b, required 0", underrun_o);
        end
        drive_hs_word(16'hBEEF, 1'b0, 3'd2);
        pkt_valid_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (lane_hs_valid_o !== 2'b00) valid_seen = 1;
        end
        checks++;
        if (valid_seen) begin
            errors++;
            $display("FAIL underrun_valid: lanes valid during starve, required 00");
        end
        checks++;
        if (underrun_o !== 1'b1) begin
            errors++;
            $display("FAIL underrun_set: got %b, required 1", underrun_o);
        end
        @(posedge clk);
        #1;
        drive_hs_word(16'hCAFE, 1'b1, 3'd2);
        wait_not_busy("underrun_idle");
        checks++;
        if (underrun_o !== 1'b1) begin
            errors++;
            $display("FAIL underrun_sticky: got %b, required 1", underrun_o);
        end
    endtask

    task automatic test_timeout();
        int ticks = 0;
        bit done = 0;
        bit accepted = 0;
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pre: got %b, required 0", timeout_o);
        end
        stuck1      = 1'b1;
        pkt_data_i  = 16'hDEAD;
        pkt_last_i  = 1'b1;
        pkt_bytes_i = 3'd2;
        pkt_valid_i = 1'b1;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (pkt_ready_o) accepted = 1;
            if (timeout_o) done = 1;
            else if ((|lane_hs_request_o) && tick_i) ticks++;
        end
        checks++;
        if (!done || ticks != 4) begin
            errors++;
            $display("FAIL timeout_ticks: timeout=%0b after %0d ticks, required 1 after 4", done, ticks);
        end
        checks++;
        if (lane_hs_request_o !== 2'b00) begin
            errors++;
            $display("FAIL timeout_req: got %b, required 00", lane_hs_request_o);
        end
        checks++;
        if (accepted) begin
            errors++;
            $display("FAIL timeout_accept: pkt accepted during failed entry, required none");
        end
        @(posedge clk);
        #1;
        pkt_valid_i = 1'b0;
        stuck1      = 1'b0;
        wait_not_busy("timeout_idle");
        checks++;
        if (timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b, required 1", timeout_o);
        end
    endtask

    task automatic test_reset_mid();
        drive_hs_word(16'h1357, 1'b0, 3'd2);
        pkt_data_i = 16'h2468;
        rst_i      = 1'b1;
        @(posedge clk);
        #1;
        pkt_valid_i = 1'b0;
        check_all_zero("reset_mid_outputs");
        rst_i = 1'b0;
        drive_hs_word(16'h9ABC, 1'b1, 3'd0);
        wait_not_busy("reset_mid_idle");
    endtask

    initial begin
        test_reset();
        test_hs_burst();
        test_lp();
        test_alternation();
        test_underrun();
        test_timeout();
        test_reset_mid();
        repeat (4) @(posedge clk);
        checks++;
        if (hs_q.size() != 0 || lp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d HS and %0d LP left, required 0 and 0",
                     hs_q.size(), lp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
